// File: rtl/sequence_detector.sv
// Counts occurrences of the four-symbol sequence SYM0,SYM1,SYM2,SYM3 on a 2-bit stream.
// Define SEQUENCE_DETECTOR_SATURATE_EN to hold the count at 15 instead of wrapping.
module sequence_detector #(
  parameter logic [1:0] SYM0 = 2'b00,
  parameter logic [1:0] SYM1 = 2'b01,
  parameter logic [1:0] SYM2 = 2'b10,
  parameter logic [1:0] SYM3 = 2'b11
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic [1:0] x1_x0,
  output logic [3:0] z3_z0
);

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  logic [1:0] state, state_nxt;
  logic [1:0] restart;
  logic       detect;

  // A mismatch can only fall back to a fresh start on SYM0, never a longer prefix.
  assign restart = (x1_x0 == SYM0) ? S1 : S0;

  always_comb begin
    state_nxt = S0;
    detect    = 1'b0;
    case (state)
      S0: state_nxt = restart;
      S1: state_nxt = (x1_x0 == SYM1) ? S2 : restart;
      S2: state_nxt = (x1_x0 == SYM2) ? S3 : restart;
      S3: begin
        if (x1_x0 == SYM3) begin
          detect    = 1'b1;
          state_nxt = (SYM3 == SYM0) ? S1 : S0;
        end else begin
          state_nxt = restart;
        end
      end
      default: state_nxt = S0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state <= S0;
    else         state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      z3_z0 <= 4'b0000;
    end else if (detect) begin
`ifdef SEQUENCE_DETECTOR_SATURATE_EN
      if (z3_z0 != 4'b1111) z3_z0 <= z3_z0 + 4'd1;
`else
      z3_z0 <= z3_z0 + 4'd1;
`endif
    end
  end

endmodule

// File: tb/tb_sequence_detector.sv
// Randomized scoreboard bench for sequence_detector; the driver pushes the
// expected count per edge and a monitor compares after each rising edge.
module tb_sequence_detector;

  logic       clock;
  logic       reset_;
  logic [1:0] x1_x0;
  logic [3:0] z3_z0;

  int tests  = 0;
  int errors = 0;
  int edge_n = 0;

  logic [3:0] exp_q[$];

  // Reference model: how many target symbols are matched, plus a raw detection count.
  logic [1:0] target [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  int matched = 0;
  int detections = 0;

  sequence_detector dut (
    .clock (clock),
    .reset_(reset_),
    .x1_x0 (x1_x0),
    .z3_z0 (z3_z0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] model_count();
`ifdef SEQUENCE_DETECTOR_SATURATE_EN
    return (detections > 15) ? 4'd15 : 4'(detections);
`else
    return 4'(detections % 16);
`endif
  endfunction

  function automatic void model_reset();
    matched    = 0;
    detections = 0;
  endfunction

  function automatic void model_sample(input logic [1:0] x);
    if (x == target[matched]) begin
      matched++;
      if (matched == 4) begin
        detections++;
        matched = (target[3] == target[0]) ? 1 : 0;
      end
    end else begin
      matched = (x == target[0]) ? 1 : 0;
    end
  endfunction

  task automatic check_now(input string name, input logic [3:0] want);
    tests++;
    if (z3_z0 !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, z3_z0, want);
    end
  endtask

  // One symbol per rising edge; inputs change in the low phase, optionally with a reset pulse first.
  task automatic step(input logic [1:0] x, input logic rst_val, input logic pulse);
    @(negedge clock);
    if (pulse) begin
      #1 reset_ = 1'b0;
      #1 model_reset();
      check_now("async_pulse", 4'd0);
      #1 reset_ = 1'b1;
    end
    reset_ = rst_val;
    x1_x0  = x;
    if (!rst_val) model_reset();
    else          model_sample(x);
    exp_q.push_back(model_count());
  endtask

  task automatic seq(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                     input logic [1:0] d);
    step(a, 1'b1, 1'b0);
    step(b, 1'b1, 1'b0);
    step(c, 1'b1, 1'b0);
    step(d, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2 reset_ = 1'b0;
    #1 model_reset();
    check_now("async_reset", 4'd0);
    repeat (3) step(2'(($urandom % 4)), 1'b0, 1'b0);
  endtask

  // Monitor: compare the registered count just after every rising edge that has an expectation.
  always @(posedge clock) begin
    #1;
    edge_n++;
    if (exp_q.size() > 0) begin
      logic [3:0] want;
      want = exp_q.pop_front();
      tests++;
      if (z3_z0 !== want) begin
        errors++;
        $display("FAIL count edge %0d: got %0d expected %0d", edge_n, z3_z0, want);
      end
    end
  end

  initial begin
    reset_ = 1'b1;
    x1_x0  = 2'b00;
    repeat (2) @(posedge clock);

    // Basic detect, then 1,2 keeps the count.
    do_reset();
    seq(0, 1, 2, 3);
    step(1, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0);
    step(3, 1'b1, 1'b0);

    // Broken sequence with restart.
    do_reset();
    step(0, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0);
    seq(0, 1, 2, 3);

    // Non-match noise.
    do_reset();
    seq(3, 2, 1, 0);
    step(2, 1'b1, 1'b0);
    step(3, 1'b1, 1'b0);

    // No prefix fallback: 0,0,1,2,3 detects once (0 restarts), 0,1,0,2,3 never does.
    do_reset();
    step(0, 1'b1, 1'b0);
    seq(0, 1, 2, 3);
    step(0, 1'b1, 1'b0);
    seq(1, 0, 2, 3);

    // Wrap or saturate after 16 (then 17) back-to-back groups.
    do_reset();
    repeat (17) seq(0, 1, 2, 3);

    // Reset mid-sequence discards progress.
    do_reset();
    step(0, 1'b1, 1'b0);
    step(1, 1'b1, 1'b0);
    step(2, 1'b1, 1'b0);
    step(3, 1'b1, 1'b1);
    seq(0, 1, 2, 3);

    // Randomized stream biased toward the target, with occasional reset pulses.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [1:0] x;
      if ($urandom_range(0, 2) == 0) x = target[matched];
      else                           x = 2'($urandom % 4);
      step(x, 1'b1, ($urandom_range(0, 99) == 0));
    end

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clock);
        budget--;
      end
      #3;
      if (exp_q.size() > 0) begin
        tests++;
        errors++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/sequence_detector.md
Name: sequence_detector

Overview:
- Synchronous detector for a fixed four-symbol sequence on a 2-bit input symbol stream; one symbol is sampled per clock rising edge.
- Counts complete occurrences of the target sequence and presents the count on a 4-bit registered output.
- Used as a standalone control/monitor block. Input symbols are assumed already synchronous to the clock.

Parameters:
- SYM0, 2'b00, first symbol of the target sequence.
- SYM1, 2'b01, second symbol of the target sequence.
- SYM2, 2'b10, third symbol of the target sequence.
- SYM3, 2'b11, fourth (final) symbol of the target sequence.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_  input  1  asynchronous, active-low reset.
- x1_x0  input  2  input symbol, sampled every rising edge.
- z3_z0  output  4  registered count of completed sequence detections.

Behaviour:
- Reset is asynchronous and active-low. While reset_=0: FSM is in state S0 and z3_z0=4'b0000, immediately and independent of the clock. Normal operation resumes on the first rising edge with reset_=1.
- Progress FSM states:
  - S0: nothing matched.
  - S1: SYM0 matched.
  - S2: SYM0,SYM1 matched.
  - S3: SYM0..SYM2 matched.
- Transitions, with x the sampled x1_x0:
  - S0: x==SYM0 -> S1; else S0.
  - S1: x==SYM1 -> S2; else if x==SYM0 -> S1; else S0.
  - S2: x==SYM2 -> S3; else if x==SYM0 -> S1; else S0.
  - S3: x==SYM3 -> detection. Next state is S1 if SYM3==SYM0, else S0. Otherwise (no match) x==SYM0 -> S1, else S0.
- Mismatch fallback only considers restarting with SYM0. No further prefix (KMP) fallback. Overlap is allowed only through the SYM3==SYM0 rule.
- Detection timing: on the rising edge that samples SYM3 while in S3, z3_z0 increments by 1. The new value is visible immediately after that edge: latency is 0 cycles after the final symbol's sampling edge.
- Output width: 4-bit unsigned, wraps 15 -> 0 (default build).
- z3_z0 changes only on detection edges or reset. It is glitch-free because it is driven directly from a register.
- Reset asserted mid-sequence: partial progress is discarded and the count is cleared. The sequence must restart from SYM0 after release.
- X/undefined input: no requirement beyond no lock-up after reset.

Optional Feature:
- Macro SEQUENCE_DETECTOR_SATURATE_EN.
- Defined: z3_z0 saturates at 4'b1111. Further detections leave it at 15; the FSM continues normally.
- Undefined: z3_z0 wraps modulo 16 (15 -> 0).

Test Plan:
- Reset: drive reset_=0 asynchronously between clock edges -> z3_z0=0 immediately; it stays 0 across edges while held.
- Basic detect: after reset, symbols 0,1,2,3 on four consecutive edges -> z3_z0 goes 0 -> 1 right after the 4th edge. Then symbols 1,2 -> z3_z0 stays 1 and the FSM ends in S0.
- Broken sequence with restart: symbols 0,1,0,1,2,3 -> z3_z0=1 after the 6th edge, and no increment earlier.
- Non-match noise: symbols 3,2,1,0,2,3 -> z3_z0 remains 0.
- Wrap vs. saturate: 16 back-to-back 0,1,2,3 groups -> z3_z0=0 in the default build; z3_z0=15 with SEQUENCE_DETECTOR_SATURATE_EN.
- Reset mid-sequence: symbols 0,1,2, then pulse reset_ low, then 3 -> no detection and z3_z0=0. Follow with 0,1,2,3 -> z3_z0=1.
